// File: rtl/archon_override_arbiter.sv
// -----------------------------------------------------------------------------
// archon_override_arbiter
//
// Purpose:
//   Arbitrates four override sources (quantum override, analog lock, analog
//   flush, ML predictor) into a single registered stall / flush / lock command
//   for the pipeline CPU. A five-state FSM (IDLE, STALL, FLUSH, LOCK, COOLDOWN)
//   sequences each grant. Every command and status output is registered, so a
//   request sampled on one rising edge shows up on the outputs right after
//   that edge.
//
// Parameters:
//   STALL_CYCLES    - cycles cmd_stall is held per stall grant      (1..255)
//   FLUSH_TIMEOUT   - max cycles spent waiting for cpu_flush_ack    (1..255)
//   LOCK_MIN        - minimum cycles cmd_lock is held per lock grant (1..255)
//   COOLDOWN_CYCLES - quiet cycles after any grant, 0 skips COOLDOWN (0..255)
//
// Ports:
//   clk                  in   system clock, rising edge
//   reset                in   synchronous, active-low reset
//   quantum_override_req in   level request for lock, highest priority
//   analog_lock_req      in   level request for lock
//   analog_flush_req     in   level request for flush
//   ml_predicted_action  in   [1:0] 00 none, 01 stall, 10 flush, 11 lock
//   cpu_flush_ack        in   one-cycle pulse, flush completed
//   cmd_stall            out  stall command (registered)
//   cmd_flush            out  flush command (registered)
//   cmd_lock             out  lock command (registered)
//   grant_src            out  [1:0] 0 quantum, 1 analog_lock, 2 analog_flush, 3 ml
//   busy                 out  FSM is not in IDLE
//   timeout_err          out  sticky flag, a flush ended without an ack
//   grant_count          out  [7:0] saturating count of grants issued
//
// Configuration macro:
//   ARCHON_ARB_ML_EN - when defined, ml_predicted_action takes part in IDLE
//                      arbitration. When undefined the port stays present but
//                      is ignored, so grant_src never reports 3.
// -----------------------------------------------------------------------------
module archon_override_arbiter #(
  parameter int unsigned STALL_CYCLES    = 4,
  parameter int unsigned FLUSH_TIMEOUT   = 8,
  parameter int unsigned LOCK_MIN        = 2,
  parameter int unsigned COOLDOWN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quantum_override_req,
  input  logic       analog_lock_req,
  input  logic       analog_flush_req,
  input  logic [1:0] ml_predicted_action,
  input  logic       cpu_flush_ack,
  output logic       cmd_stall,
  output logic       cmd_flush,
  output logic       cmd_lock,
  output logic [1:0] grant_src,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] grant_count
);

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    FLUSH,
    LOCK,
    COOLDOWN
  } state_t;

  localparam logic [1:0] SRC_QUANTUM = 2'd0;
  localparam logic [1:0] SRC_ALOCK   = 2'd1;
  localparam logic [1:0] SRC_AFLUSH  = 2'd2;
  localparam logic [1:0] SRC_ML      = 2'd3;

  localparam logic [7:0] STALL_LEN = 8'(STALL_CYCLES);
  localparam logic [7:0] FLUSH_LEN = 8'(FLUSH_TIMEOUT);
  localparam logic [7:0] LOCK_LEN  = 8'(LOCK_MIN);
  localparam logic [7:0] COOL_LEN  = 8'(COOLDOWN_CYCLES);

  // Where a finished grant goes: a zero-length cooldown drops straight to IDLE.
  localparam state_t     EXIT_STATE = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
  localparam logic [7:0] EXIT_CNT   = (COOLDOWN_CYCLES == 0) ? 8'd0 : 8'd1;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] phase_cnt_q;
  logic [7:0] phase_cnt_d;
  logic [1:0] src_d;
  logic       grant;
  logic       timeout_hit;

  logic       lock_req;
  logic [1:0] lock_src;
  logic       lock_src_active;
  logic [1:0] ml_action;

  // With the ML predictor compiled out the port is tied off internally to
  // "no action"; the reduction keeps the unused input visible to lint.
`ifdef ARCHON_ARB_ML_EN
  assign ml_action = ml_predicted_action;
`else
  logic unused_ml;
  assign unused_ml = ^ml_predicted_action;
  assign ml_action = 2'b00;
`endif

  // Hardware lock sources; quantum outranks analog when both are high.
  assign lock_req = quantum_override_req | analog_lock_req;
  assign lock_src = quantum_override_req ? SRC_QUANTUM : SRC_ALOCK;

  // Level of whichever source won the current lock. An ML lock has no level
  // to follow, so it releases purely on LOCK_MIN.
  always_comb begin
    lock_src_active = 1'b0;
    case (grant_src)
      SRC_QUANTUM: lock_src_active = quantum_override_req;
      SRC_ALOCK:   lock_src_active = analog_lock_req;
      default:     lock_src_active = 1'b0;
    endcase
  end

  // Next-state logic. phase_cnt counts the cycles spent in the current phase
  // starting at 1 on entry; LOCK stops counting once LOCK_MIN is reached so
  // a long-held lock cannot wrap the counter. Any move into STALL, FLUSH or
  // LOCK (including a preemption) raises grant for one cycle.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    src_d       = grant_src;
    grant       = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (lock_req) begin
          state_d     = LOCK;
          src_d       = lock_src;
          phase_cnt_d = 8'd1;
          grant       = 1'b1;
        end else if (analog_flush_req) begin
          state_d     = FLUSH;
          src_d       = SRC_AFLUSH;
          phase_cnt_d = 8'd1;
          grant       = 1'b1;
        end else if (ml_action != 2'b00) begin
          src_d       = SRC_ML;
          phase_cnt_d = 8'd1;
          grant       = 1'b1;
          case (ml_action)
            2'b11:   state_d = LOCK;
            2'b10:   state_d = FLUSH;
            default: state_d = STALL;
          endcase
        end
      end

      STALL: begin
        if (lock_req) begin
          state_d     = LOCK;
          src_d       = lock_src;
          phase_cnt_d = 8'd1;
          grant       = 1'b1;
        end else if (analog_flush_req) begin
          state_d     = FLUSH;
          src_d       = SRC_AFLUSH;
          phase_cnt_d = 8'd1;
          grant       = 1'b1;
        end else if (phase_cnt_q == STALL_LEN) begin
          state_d     = EXIT_STATE;
          phase_cnt_d = EXIT_CNT;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end

      // Not preemptible. An ack arriving on the final counted cycle still
      // wins over the timeout.
      FLUSH: begin
        if (cpu_flush_ack) begin
          state_d     = EXIT_STATE;
          phase_cnt_d = EXIT_CNT;
        end else if (phase_cnt_q == FLUSH_LEN) begin
          state_d     = EXIT_STATE;
          phase_cnt_d = EXIT_CNT;
          timeout_hit = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end

      LOCK: begin
        if (phase_cnt_q >= LOCK_LEN) begin
          if (!lock_src_active) begin
            state_d     = EXIT_STATE;
            phase_cnt_d = EXIT_CNT;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end

      // Only hardware lock requests may cut the quiet period short; other
      // requests that stay high are picked up once back in IDLE.
      COOLDOWN: begin
        if (lock_req) begin
          state_d     = LOCK;
          src_d       = lock_src;
          phase_cnt_d = 8'd1;
          grant       = 1'b1;
        end else if (phase_cnt_q == COOL_LEN) begin
          state_d     = IDLE;
          phase_cnt_d = 8'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        phase_cnt_d = 8'd0;
      end
    endcase
  end

  // State, counters and outputs. Commands are decoded from the next state so
  // they come out of flops aligned with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_cnt_q <= 8'd0;
      grant_src   <= SRC_QUANTUM;
      cmd_stall   <= 1'b0;
      cmd_flush   <= 1'b0;
      cmd_lock    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      grant_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      grant_src   <= src_d;
      cmd_stall   <= (state_d == STALL);
      cmd_flush   <= (state_d == FLUSH);
      cmd_lock    <= (state_d == LOCK);
      busy        <= (state_d != IDLE);
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if (grant && (grant_count != 8'hFF)) begin
        grant_count <= grant_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/archon_override_arbiter.md
ARCHON_OVERRIDE_ARBITER -- requirements
Module: archon_override_arbiter

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 4, cycles cmd_stall is held per stall grant (1..255).
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 8, maximum cycles spent waiting for cpu_flush_ack (1..255).
REQ-003 SHALL have parameter LOCK_MIN, default 2, minimum cycles cmd_lock is held per lock grant (1..255).
REQ-004 SHALL have parameter COOLDOWN_CYCLES, default 3, quiet cycles after any grant (0..255).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port quantum_override_req  input  1  level request: lock (highest priority).
REQ-008 SHALL have port analog_lock_req  input  1  level request: lock.
REQ-009 SHALL have port analog_flush_req  input  1  level request: flush.
REQ-010 SHALL have port ml_predicted_action  input  2  00 none, 01 stall, 10 flush, 11 lock (lowest priority).
REQ-011 SHALL have port cpu_flush_ack  input  1  one-cycle pulse from CPU when a flush has completed.
REQ-012 SHALL have ports cmd_stall, cmd_flush, cmd_lock  output  1 each  registered commands to the pipeline CPU.
REQ-013 SHALL have port grant_src  output  2  source of current grant: 0 quantum, 1 analog_lock, 2 analog_flush, 3 ml.
REQ-014 SHALL have ports busy  output  1  (state != IDLE) and timeout_err  output  1  sticky flush-timeout flag.
REQ-015 SHALL have port grant_count  output  8  saturating count of grants issued.

Function
REQ-016 SHALL implement FSM states IDLE, STALL, FLUSH, LOCK, COOLDOWN; outputs are registered and valid the cycle after the transition decision (1-cycle request-to-command latency).
REQ-017 In IDLE, priority SHALL be quantum > analog_lock > analog_flush > ml; lock sources -> LOCK, analog_flush -> FLUSH, ml 11/10/01 -> LOCK/FLUSH/STALL, ml 00 stays IDLE.
REQ-018 Exactly one of cmd_stall/cmd_flush/cmd_lock SHALL be 1 in STALL/FLUSH/LOCK respectively; all SHALL be 0 in IDLE and COOLDOWN.
REQ-019 STALL SHALL last STALL_CYCLES cycles then go to COOLDOWN; a lock request during STALL preempts to LOCK next cycle; a flush request during STALL preempts to FLUSH.
REQ-020 FLUSH SHALL be non-preemptible; exit to COOLDOWN on cpu_flush_ack, or after FLUSH_TIMEOUT cycles without ack, setting timeout_err (sticky until reset).
REQ-021 cpu_flush_ack outside FLUSH SHALL be ignored; ack on the timeout cycle counts as ack (timeout_err not set).
REQ-022 LOCK SHALL hold at least LOCK_MIN cycles and until the granting lock source is deasserted (ml lock: LOCK_MIN only), then go to COOLDOWN.
REQ-023 COOLDOWN SHALL last COOLDOWN_CYCLES (0 = skip directly to IDLE); a quantum or analog lock request preempts to LOCK; other requests ignored (levels still high are taken in IDLE).
REQ-024 grant_count SHALL increment by 1 on every entry into STALL, FLUSH or LOCK (including preemptions), saturating at 255.
REQ-025 grant_src SHALL update on each grant and hold its value through COOLDOWN and IDLE.

Reset
REQ-026 While reset=0 at a clock edge: state IDLE, all cmd_* 0, grant_src 0, busy 0, timeout_err 0, grant_count 0, all counters 0; applies mid-operation, commands drop the cycle after.

Configuration
REQ-027 With macro ARCHON_ARB_ML_EN defined, ml_predicted_action SHALL participate as in REQ-017; without it, the port SHALL remain present but be ignored, grant_src never equals 3.

Verification
REQ-028 analog_flush_req and ml=01 in same cycle, ack 3 cycles later -> cmd_flush 3 cycles, grant_src=2, COOLDOWN 3 cycles, grant_count=1.
REQ-029 ml=01 alone -> cmd_stall exactly 4 cycles; analog_lock_req raised in stall cycle 2 -> cmd_lock next cycle, grant_count=2.
REQ-030 analog_flush_req, no ack -> cmd_flush 8 cycles, timeout_err=1 and remains 1 through later grants.
REQ-031 quantum_override_req held 6 cycles -> cmd_lock 6 cycles, grant_src=0; held 1 cycle -> cmd_lock 2 cycles (LOCK_MIN).
REQ-032 reset=0 asserted during LOCK -> next cycle all outputs 0, busy 0, grant_count 0.
REQ-033 300 back-to-back ml stall grants -> grant_count saturates at 255; without ARCHON_ARB_ML_EN, ml=11 -> no command, busy 0.
